// File: rtl/rect_filler_if.sv
// ---------------------------------------------------------------------------
// rect_filler_if
//   Bundles the rectangle command handshake and the frame-buffer write port
//   used by rect_filler.
//   Parameters : HOR_ACTIVE_PIXELS / VER_ACTIVE_PIXELS (frame size).
//   Signals    : cmd_valid, cmd_ready, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
//                busy, wr_en, wr_addr, wr_data.
//   Modports   : master (command source / write sink), slave (rect_filler).
// ---------------------------------------------------------------------------
interface rect_filler_if #(
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 480
);
  localparam int X_WIDTH          = $clog2(HOR_ACTIVE_PIXELS);
  localparam int Y_WIDTH          = $clog2(VER_ACTIVE_PIXELS);
  localparam int PIXEL_ADDR_WIDTH = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS);

  logic                        cmd_valid;
  logic                        cmd_ready;
  logic [X_WIDTH-1:0]          cmd_x;
  logic [Y_WIDTH-1:0]          cmd_y;
  logic [X_WIDTH:0]            cmd_w;
  logic [Y_WIDTH:0]            cmd_h;
  logic                        cmd_color;
  logic                        busy;
  logic                        wr_en;
  logic [PIXEL_ADDR_WIDTH-1:0] wr_addr;
  logic                        wr_data;

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    input  cmd_ready, busy, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    output cmd_ready, busy, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/rect_filler.sv
// ---------------------------------------------------------------------------
// rect_filler
//   Fills an axis-aligned rectangle of a 1-bit frame buffer with a constant
//   colour, one pixel per enabled clock, in raster order.
//   Ports:
//     clk   - renderer clock, rising edge
//     rst_n - synchronous active-low reset (wins over ce)
//     ce    - clock enable; when low all state holds and no write is issued
//     bus   - rect_filler_if.slave: command handshake + frame-buffer write
//   Configuration:
//     RECT_FILLER_CLIP_EN - when defined, rectangles are clipped to the frame;
//                           otherwise they are used as given and addresses
//                           wrap modulo 2^PIXEL_ADDR_WIDTH.
// ---------------------------------------------------------------------------
module rect_filler #(
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 480
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  rect_filler_if.slave  bus
);
  localparam int X_WIDTH          = $clog2(HOR_ACTIVE_PIXELS);
  localparam int Y_WIDTH          = $clog2(VER_ACTIVE_PIXELS);
  localparam int PIXEL_ADDR_WIDTH = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS);

  localparam logic [PIXEL_ADDR_WIDTH-1:0] H_ADDR = PIXEL_ADDR_WIDTH'(HOR_ACTIVE_PIXELS);
  localparam logic [PIXEL_ADDR_WIDTH-1:0] ONE_A  = PIXEL_ADDR_WIDTH'(1);
  localparam logic [X_WIDTH:0]            ONE_W  = (X_WIDTH+1)'(1);
  localparam logic [Y_WIDTH:0]            ONE_H  = (Y_WIDTH+1)'(1);

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t                      state, state_nxt;
  logic                        ready_q, ready_nxt;
  logic                        busy_q, busy_nxt;
  logic                        wr_en_q, wr_en_nxt;
  logic                        wr_data_q, wr_data_nxt;
  logic [PIXEL_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_nxt;
  logic [PIXEL_ADDR_WIDTH-1:0] row_base_q, row_base_nxt;
  logic [X_WIDTH:0]            w_q, w_nxt, col_q, col_nxt;
  logic [Y_WIDTH:0]            h_q, h_nxt, row_q, row_nxt;

  logic [X_WIDTH:0]            eff_w;
  logic [Y_WIDTH:0]            eff_h;
  logic [PIXEL_ADDR_WIDTH-1:0] start_addr;
  logic                        accept, empty, last_col, last_row;

  // ce is applied in the register enable, so accept only needs valid & ready.
  assign accept   = bus.cmd_valid & ready_q;
  assign empty    = (eff_w == '0) || (eff_h == '0);
  assign last_col = (col_q + ONE_W) == w_q;
  assign last_row = (row_q + ONE_H) == h_q;

  // The one multiply happens once per command; the pixel loop only adds.
  assign start_addr = PIXEL_ADDR_WIDTH'(bus.cmd_y) * H_ADDR + PIXEL_ADDR_WIDTH'(bus.cmd_x);

  // Effective rectangle size seen by the fill loop.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    eff_w = bus.cmd_w;
    eff_h = bus.cmd_h;
`ifdef RECT_FILLER_CLIP_EN
    if ({1'b0, bus.cmd_x} >= (X_WIDTH+1)'(HOR_ACTIVE_PIXELS) ||
        {1'b0, bus.cmd_y} >= (Y_WIDTH+1)'(VER_ACTIVE_PIXELS)) begin
      eff_w = '0;
      eff_h = '0;
    end else begin
      if (bus.cmd_w > (X_WIDTH+1)'(HOR_ACTIVE_PIXELS) - {1'b0, bus.cmd_x})
        eff_w = (X_WIDTH+1)'(HOR_ACTIVE_PIXELS) - {1'b0, bus.cmd_x};
      if (bus.cmd_h > (Y_WIDTH+1)'(VER_ACTIVE_PIXELS) - {1'b0, bus.cmd_y})
        eff_h = (Y_WIDTH+1)'(VER_ACTIVE_PIXELS) - {1'b0, bus.cmd_y};
    end
`endif
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the latched command is reset too, so a fill aborted by reset leaves
      // nothing behind that could be resumed.
      state      <= IDLE;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= 1'b0;
      wr_addr_q  <= '0;
      row_base_q <= '0;
      w_q        <= '0;
      h_q        <= '0;
      col_q      <= '0;
      row_q      <= '0;
    end else if (ce) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= state_nxt;
      ready_q    <= ready_nxt;
      busy_q     <= busy_nxt;
      wr_en_q    <= wr_en_nxt;
      wr_data_q  <= wr_data_nxt;
      wr_addr_q  <= wr_addr_nxt;
      row_base_q <= row_base_nxt;
      w_q        <= w_nxt;
      h_q        <= h_nxt;
      col_q      <= col_nxt;
      row_q      <= row_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !empty)    state_nxt = FILL;
      FILL:    if (last_col && last_row) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and pixel counters.
  always_comb begin
    ready_nxt    = (state_nxt == IDLE);
    busy_nxt     = (state_nxt == FILL);
    wr_en_nxt    = (state_nxt == FILL);
    wr_data_nxt  = wr_data_q;
    wr_addr_nxt  = wr_addr_q;
    row_base_nxt = row_base_q;
    w_nxt        = w_q;
    h_nxt        = h_q;
    col_nxt      = col_q;
    row_nxt      = row_q;
    case (state)
      IDLE: begin
        if (accept) begin
          w_nxt        = eff_w;
          h_nxt        = eff_h;
          col_nxt      = '0;
          row_nxt      = '0;
          wr_addr_nxt  = start_addr;
          row_base_nxt = start_addr;
          wr_data_nxt  = bus.cmd_color;
        end
      end
      FILL: begin
        // Row wrap goes straight to the next row start: no idle cycle.
        if (last_col) begin
          col_nxt      = '0;
          row_nxt      = row_q + ONE_H;
          row_base_nxt = row_base_q + H_ADDR;
          wr_addr_nxt  = row_base_q + H_ADDR;
        end else begin
          col_nxt      = col_q + ONE_W;
          wr_addr_nxt  = wr_addr_q + ONE_A;
        end
      end
      default: ;
    endcase
  end

  // Handshake and write strobe are registered and qualified by ce, so a
  // stalled cycle neither offers ready nor issues a write.
  assign bus.cmd_ready = ready_q & ce;
  assign bus.wr_en     = wr_en_q & ce;
  assign bus.busy      = busy_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
endmodule
